// File: rtl/ternary_weight_unpacker_pkg.sv
// Shared types and constants for the ternary weight unpacker.
// Trit codes follow the systolic array's lane format: bit 1 is the sign, and OR of both bits is non-zero.
package ternary_weight_unpacker_pkg;

   typedef logic [1:0] trit_t;

   localparam trit_t W_ZERO = 2'b00;
   localparam trit_t W_POS  = 2'b01;
   localparam trit_t W_NEG  = 2'b11;

   localparam int unsigned TRITS_PER_BYTE = 5;
   localparam int unsigned MAX_PACKED     = 242;

   // Base-3 digit (0, 1, 2) to array lane code.
   function automatic trit_t trit_to_code(input logic [1:0] i_digit);
      trit_t r_code;
      case (i_digit)
         2'd1:    r_code = W_POS;
         2'd2:    r_code = W_NEG;
         default: r_code = W_ZERO;
      endcase
      return r_code;
   endfunction

endpackage

// File: rtl/ternary_weight_unpacker_if.sv
// Generic valid/ready stream bundle.
// Used for both the packed-byte input and the weight-group output.
interface ternary_weight_unpacker_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/ternary_byte_decoder.sv
// Combinational base-3 decoder: splits one packed byte into five trit codes, trit 0 first.
// Bytes above 242 are flagged invalid and decode to all-zero trits.
module ternary_byte_decoder
   import ternary_weight_unpacker_pkg::*;
(
   input  logic                             [7:0] i_byte,
   output trit_t [TRITS_PER_BYTE-1:0]             o_codes,
   output logic                                   o_invalid
);

   logic [7:0] w_rem;

   always_comb begin
      o_invalid = (i_byte > 8'(MAX_PACKED));
      w_rem     = i_byte;
      o_codes   = '0;
      for (int i = 0; i < int'(TRITS_PER_BYTE); i++) begin
         o_codes[i] = o_invalid ? W_ZERO : trit_to_code(2'(w_rem % 8'd3));
         w_rem      = w_rem / 8'd3;
      end
   end

endmodule

// File: rtl/ternary_weight_unpacker.sv
// Buffers base-3 packed weights (5 trits/byte) and emits LANES trit codes per output beat.
// Storage is a head-aligned shift register: pops shift down by LANES, pushes land after the survivors.
module ternary_weight_unpacker
   import ternary_weight_unpacker_pkg::*;
#(
   parameter int unsigned LANES     = 4,
   parameter int unsigned BUF_TRITS = 12,
   parameter int unsigned CNT_W     = $clog2(BUF_TRITS + 1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_clear,
   ternary_weight_unpacker_if.slave      i_in,
   ternary_weight_unpacker_if.master     o_out,
   output logic [CNT_W-1:0]              o_fill,
   output logic                          o_err_invalid
);

   trit_t                       r_buf [BUF_TRITS];
   trit_t                       w_buf_d [BUF_TRITS];
   logic [CNT_W-1:0]            r_count;
   logic                        r_err;

   trit_t [TRITS_PER_BYTE-1:0]  w_codes;
   logic                        w_invalid;
   logic                        w_push;
   logic                        w_pop;
   logic                        w_out_valid;
   int unsigned                 w_count;
   int unsigned                 w_base;
   int unsigned                 w_count_d;

   ternary_byte_decoder u_decoder (
      .i_byte    (i_in.data),
      .o_codes   (w_codes),
      .o_invalid (w_invalid)
   );

   assign w_count     = 32'(r_count);
   assign w_out_valid = (w_count >= LANES);
   // Ready looks only at the current count; a same-cycle pop earns no credit.
   assign i_in.ready  = !i_clear && ((w_count + TRITS_PER_BYTE) <= BUF_TRITS);
   assign w_push      = i_in.valid && i_in.ready;
   assign w_pop       = w_out_valid && o_out.ready && !i_clear;

   assign o_out.valid   = w_out_valid;
   assign o_fill        = r_count;
   assign o_err_invalid = r_err;

   always_comb begin
      o_out.data = '0;
      if (w_out_valid) begin
         for (int k = 0; k < int'(LANES); k++) begin
            o_out.data[2*k +: 2] = r_buf[k];
         end
      end
   end

   always_comb begin
      w_base    = w_pop ? (w_count - LANES) : w_count;
      w_count_d = w_base + (w_push ? TRITS_PER_BYTE : 0);
      for (int j = 0; j < int'(BUF_TRITS); j++) begin
         w_buf_d[j] = r_buf[j];
      end
      if (w_pop) begin
         for (int j = 0; j < int'(BUF_TRITS - LANES); j++) begin
            w_buf_d[j] = r_buf[j + int'(LANES)];
         end
         for (int j = int'(BUF_TRITS - LANES); j < int'(BUF_TRITS); j++) begin
            w_buf_d[j] = W_ZERO;
         end
      end
      if (w_push) begin
         for (int j = 0; j < int'(BUF_TRITS); j++) begin
            if ((32'(j) >= w_base) && (32'(j) < w_base + TRITS_PER_BYTE)) begin
               w_buf_d[j] = w_codes[3'(32'(j) - w_base)];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_err   <= 1'b0;
         for (int j = 0; j < int'(BUF_TRITS); j++) begin
            r_buf[j] <= W_ZERO;
         end
      end else if (i_clear) begin
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_count <= CNT_W'(w_count_d);
         r_err   <= r_err | (w_push & w_invalid);
         for (int j = 0; j < int'(BUF_TRITS); j++) begin
            r_buf[j] <= w_buf_d[j];
         end
      end
   end

endmodule

// File: tb/tb_ternary_weight_unpacker.sv
// Directed self-checking bench for ternary_weight_unpacker (LANES=4, BUF_TRITS=12).
// Inputs change on the falling edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_ternary_weight_unpacker;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic [3:0] fill;
   logic       err_invalid;

   int n_checks = 0;
   int n_fail   = 0;
   int accepts;
   int beats;

   ternary_weight_unpacker_if #(.WIDTH(8)) in_bus ();
   ternary_weight_unpacker_if #(.WIDTH(8)) out_bus ();

   ternary_weight_unpacker #(
      .LANES     (4),
      .BUF_TRITS (12)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_clear       (clear),
      .i_in          (in_bus),
      .o_out         (out_bus),
      .o_fill        (fill),
      .o_err_invalid (err_invalid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic do_clear();
      next_cycle();
      clear = 1'b1;
      #1 check("clear_ready", 32'(in_bus.ready), 32'd0);
      next_cycle();
      clear = 1'b0;
      #1 check("clear_fill", 32'(fill), 32'd0);
   endtask

   initial begin
      rst_n         = 1'b0;
      clear         = 1'b0;
      in_bus.valid  = 1'b0;
      in_bus.data   = 8'd0;
      out_bus.ready = 1'b0;
      #3;
      check("rst_out_valid", 32'(out_bus.valid), 32'd0);
      check("rst_in_ready", 32'(in_bus.ready), 32'd1);
      check("rst_weights", 32'(out_bus.data), 32'h00);
      check("rst_fill", 32'(fill), 32'd0);
      check("rst_err", 32'(err_invalid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Byte 5 = trits 2,1,0,0,0 -> lanes -1,+1,0,0
      next_cycle();
      in_bus.valid = 1'b1; in_bus.data = 8'd5; out_bus.ready = 1'b1;
      #1 check("b5_in_ready", 32'(in_bus.ready), 32'd1);
      next_cycle();
      in_bus.valid = 1'b0;
      #1 check("b5_out_valid", 32'(out_bus.valid), 32'd1);
      check("b5_weights", 32'(out_bus.data), 32'h07);
      check("b5_fill_pre", 32'(fill), 32'd5);
      next_cycle();
      #1 check("b5_fill_post", 32'(fill), 32'd1);
      check("b5_partial_valid", 32'(out_bus.valid), 32'd0);
      check("b5_partial_zero", 32'(out_bus.data), 32'h00);
      do_clear();

      // 242 (all -1) then 0, pushed back to back while popping
      next_cycle();
      in_bus.valid = 1'b1; in_bus.data = 8'd242; out_bus.ready = 1'b1;
      next_cycle();
      in_bus.data = 8'd0;
      #1 check("b242_weights", 32'(out_bus.data), 32'hFF);
      check("b242_in_ready", 32'(in_bus.ready), 32'd1);
      next_cycle();
      in_bus.valid = 1'b0;
      #1 check("b0_weights", 32'(out_bus.data), 32'h03);
      next_cycle();
      #1 check("b0_fill", 32'(fill), 32'd2);
      check("b0_out_valid", 32'(out_bus.valid), 32'd0);
      do_clear();

      // 100 = trits 1,0,2,0,1 -> lanes +1,0,-1,0
      next_cycle();
      in_bus.valid = 1'b1; in_bus.data = 8'd100;
      next_cycle();
      in_bus.valid = 1'b0;
      #1 check("b100_weights", 32'(out_bus.data), 32'h31);
      next_cycle();
      #1 check("b100_fill", 32'(fill), 32'd1);
      do_clear();

      // Fill to capacity with out_ready low
      next_cycle();
      in_bus.valid = 1'b1; in_bus.data = 8'd1; out_bus.ready = 1'b0;
      #1 check("full_ready0", 32'(in_bus.ready), 32'd1);
      next_cycle();
      #1 check("full_fill5", 32'(fill), 32'd5);
      check("full_ready5", 32'(in_bus.ready), 32'd1);
      next_cycle();
      #1 check("full_fill10", 32'(fill), 32'd10);
      check("full_ready10", 32'(in_bus.ready), 32'd0);
      next_cycle();
      #1 check("full_hold", 32'(fill), 32'd10);
      in_bus.valid = 1'b0; out_bus.ready = 1'b1;
      #1 check("drain_beat0", 32'(out_bus.data), 32'h01);
      next_cycle();
      #1 check("drain_fill6", 32'(fill), 32'd6);
      check("drain_ready6", 32'(in_bus.ready), 32'd1);
      check("drain_beat1", 32'(out_bus.data), 32'h04);
      next_cycle();
      #1 check("drain_fill2", 32'(fill), 32'd2);
      check("drain_valid", 32'(out_bus.valid), 32'd0);
      do_clear();

      // Invalid byte is stored as zeros and sets the sticky flag
      next_cycle();
      in_bus.valid = 1'b1; in_bus.data = 8'd243; out_bus.ready = 1'b0;
      next_cycle();
      in_bus.valid = 1'b0;
      #1 check("inv_err", 32'(err_invalid), 32'd1);
      check("inv_fill", 32'(fill), 32'd5);
      check("inv_valid", 32'(out_bus.valid), 32'd1);
      check("inv_weights", 32'(out_bus.data), 32'h00);
      next_cycle();
      #1 check("inv_err_held", 32'(err_invalid), 32'd1);
      in_bus.valid = 1'b1; in_bus.data = 8'd7; out_bus.ready = 1'b1;
      clear = 1'b1;
      #1 check("inv_clear_ready", 32'(in_bus.ready), 32'd0);
      next_cycle();
      clear = 1'b0; in_bus.valid = 1'b0;
      #1 check("inv_clear_fill", 32'(fill), 32'd0);
      check("inv_clear_err", 32'(err_invalid), 32'd0);

      // Steady streaming of four 121 bytes (all +1)
      accepts = 0;
      beats   = 0;
      next_cycle();
      in_bus.valid = 1'b1; in_bus.data = 8'd121; out_bus.ready = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         #1;
         if (out_bus.valid) begin
            check("stream_beat", 32'(out_bus.data), 32'h55);
            beats++;
         end
         if (in_bus.valid && in_bus.ready) accepts++;
         next_cycle();
         if (accepts == 4) in_bus.valid = 1'b0;
      end
      check("stream_beats", 32'(beats), 32'd5);
      check("stream_accepts", 32'(accepts), 32'd4);
      check("stream_fill", 32'(fill), 32'd0);
      check("stream_valid", 32'(out_bus.valid), 32'd0);

      // Asynchronous reset while holding data
      in_bus.valid = 1'b1; in_bus.data = 8'd121; out_bus.ready = 1'b0;
      next_cycle();
      in_bus.valid = 1'b0;
      #1 check("arst_pre_fill", 32'(fill), 32'd5);
      #1 rst_n = 1'b0;
      #1 check("arst_fill", 32'(fill), 32'd0);
      check("arst_valid", 32'(out_bus.valid), 32'd0);
      check("arst_weights", 32'(out_bus.data), 32'h00);
      check("arst_ready", 32'(in_bus.ready), 32'd1);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
